decoder_rr_arbiter: RTL and testbench
=====================================

DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter: DWELL, default 4, number of cycles a grant drives the shared decoder4; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  request per requester; req[i] from requester i.
REQ-005 code  input  16  packed select codes; requester i owns code[4i+3:4i].
REQ-006 dec_in  output  4  drives the in port of the shared decoder4.
REQ-007 dec_en  output  1  high while dec_in carries a granted code.
REQ-008 grant  output  4  one-hot owner of the decoder; all-zero when idle.
REQ-009 done  output  4  one-cycle pulse to requester i when its dwell ends.
REQ-010 busy  output  1  high while in HOLD.

Function
REQ-011 The FSM SHALL have two states: IDLE and HOLD.
REQ-012 IDLE with req==0: all outputs stay 0 and the state stays IDLE.
REQ-013 IDLE with req!=0 at a rising edge: after that edge, grant = onehot(winner), dec_in = winner's code sampled at that edge, dec_en=1, busy=1, state=HOLD, dwell counter=DWELL-1.
REQ-014 The winner SHALL be the first set req bit searching ptr, ptr+1, ... modulo 4.
REQ-015 ptr (2 bits) SHALL become (winner+1) mod 4 when that grant ends.
REQ-016 In HOLD, dec_in SHALL hold the captured code; changes on code SHALL be ignored.
REQ-017 In HOLD, changes on req SHALL be ignored, including withdrawal by the owner; there is no abort.
REQ-018 In HOLD, the counter SHALL decrement each edge while nonzero.
REQ-019 At the edge where the counter is 0, the block SHALL clear grant, dec_en and busy, set dec_in=0, pulse done[winner]=1 for exactly one cycle, and return to IDLE.
REQ-020 grant and dec_en SHALL be high for exactly DWELL consecutive cycles per grant.
REQ-021 After every grant there SHALL be exactly one gap cycle with dec_en=0, coinciding with the done pulse.
REQ-022 req sampled during the done cycle SHALL be arbitrated normally, including by the owner that just finished.
REQ-023 dec_in SHALL be 4'b0000 whenever dec_en=0.
REQ-024 grant SHALL never have more than one bit set.
REQ-025 done SHALL never have more than one bit set.
REQ-026 done SHALL equal the grant of the immediately preceding cycle.
REQ-027 With DWELL=1, grant SHALL last one cycle, followed by the done/gap cycle.

Reset
REQ-028 When rst_n=0 at a rising edge, the following SHALL all be 0 after that edge: state=IDLE, ptr, counter, dec_in, dec_en, grant, done and busy.
REQ-029 Reset during HOLD SHALL abort the grant without a done pulse, and rst_n=0 SHALL override all requests.

Verification
REQ-030 DWELL=4, req=4'b0100, code[11:8]=4'hA -> for 4 cycles grant=4'b0100, dec_in=4'hA, dec_en=1, busy=1; then one cycle done=4'b0100, dec_en=0, dec_in=0; then idle once req drops.
REQ-031 DWELL=4, req=4'b1111 held, codes 1,2,3,4 -> grant sequence 0001,0010,0100,1000,0001; 5-cycle period; dec_in 1,2,3,4,1; a done pulse after each grant.
REQ-032 Fairness: grant0 completes, then req=4'b0011 -> grant=4'b0010 next; then req=4'b0011 again -> grant=4'b0001.
REQ-033 Code change to 4'hF in the 2nd HOLD cycle of a grant with code 4'h3 -> dec_in stays 4'h3 for the full dwell.
REQ-034 rst_n=0 in the 2nd HOLD cycle of grant2 -> next cycle all outputs 0 with no done; after release, req=4'b0011 -> grant=4'b0001 (ptr=0).
REQ-035 DWELL=1, req=4'b1000 -> grant=4'b1000 for one cycle, next cycle done=4'b1000, then regrant if req is still high.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of a shared decoder4: the winner's code is
// captured and driven for DWELL cycles, then a one-cycle done/gap.
module decoder_rr_arbiter #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] code,
  output logic [3:0]  dec_in,
  output logic        dec_en,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(DWELL - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  win_q, win_d;
  logic [3:0]  dec_in_q, dec_in_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;

  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic [3:0]  pick_code;

  // First set request at or after ptr, wrapping modulo 4
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign pick_code = code[{pick, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
      dec_in_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      dec_in_q <= dec_in_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|req) state_d = HOLD;
      HOLD: if (cnt_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    dec_in_d = dec_in_q;
    grant_d  = grant_q;
    done_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d    = pick;
          cnt_d    = CNT_INIT;
          dec_in_d = pick_code;
          grant_d  = 4'b0001 << pick;
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          done_d   = grant_q;
          grant_d  = '0;
          dec_in_d = '0;
          ptr_d    = win_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  assign dec_in = dec_in_q;
  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = (state_q == HOLD);
  assign dec_en = (state_q == HOLD);

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: DWELL=4 and DWELL=1 instances
// against a remaining-cycles reference model.
module tb_decoder_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] code;

  logic [3:0]  dec_in4, grant4, done4;
  logic        dec_en4, busy4;
  logic [3:0]  dec_in1, grant1, done1;
  logic        dec_en1, busy1;

  int n_tot = 0;
  int n_pass = 0;

  int m_left[2];
  int m_owner[2];
  int m_ptr[2];
  bit m_done[2];
  logic [3:0] m_code[2];

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code),
    .dec_in(dec_in4), .dec_en(dec_en4), .grant(grant4),
    .done(done4), .busy(busy4)
  );

  decoder_rr_arbiter #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code),
    .dec_in(dec_in1), .dec_en(dec_en1), .grant(grant1),
    .done(done1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // m_left counts grant cycles still to be shown, including the current one
  task automatic model_edge(input int u, input int dw);
    int w;
    if (!rst_n) begin
      m_left[u] = 0; m_ptr[u] = 0; m_done[u] = 0;
      m_owner[u] = 0; m_code[u] = 0;
    end else if (m_left[u] > 1) begin
      m_left[u]--;
      m_done[u] = 0;
    end else if (m_left[u] == 1) begin
      m_left[u] = 0;
      m_done[u] = 1;
      m_ptr[u] = (m_owner[u] + 1) % 4;
    end else begin
      m_done[u] = 0;
      if (req != 0) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(m_ptr[u] + k) % 4]) w = (m_ptr[u] + k) % 4;
        m_owner[u] = w;
        m_code[u] = code[4*w +: 4];
        m_left[u] = dw;
      end
    end
  endtask

  function automatic logic [3:0] e_grant(input int u);
    return (m_left[u] > 0) ? 4'(1 << m_owner[u]) : 4'b0;
  endfunction
  function automatic logic [3:0] e_done(input int u);
    return m_done[u] ? 4'(1 << m_owner[u]) : 4'b0;
  endfunction
  function automatic logic [3:0] e_dec(input int u);
    return (m_left[u] > 0) ? m_code[u] : 4'b0;
  endfunction

  task automatic check_model();
    chk("m4_grant", 16'(grant4), 16'(e_grant(0)));
    chk("m4_done", 16'(done4), 16'(e_done(0)));
    chk("m4_dec_in", 16'(dec_in4), 16'(e_dec(0)));
    chk("m4_dec_en", 16'(dec_en4), 16'(m_left[0] > 0));
    chk("m4_busy", 16'(busy4), 16'(m_left[0] > 0));
    chk("m1_grant", 16'(grant1), 16'(e_grant(1)));
    chk("m1_done", 16'(done1), 16'(e_done(1)));
    chk("m1_dec_in", 16'(dec_in1), 16'(e_dec(1)));
    chk("m1_dec_en", 16'(dec_en1), 16'(m_left[1] > 0));
    chk("m1_busy", 16'(busy1), 16'(m_left[1] > 0));
  endtask

  task automatic step(input logic [3:0] r, input logic [15:0] c,
                      input logic rs);
    req = r; code = c; rst_n = rs;
    @(posedge clk);
    model_edge(0, 4);
    model_edge(1, 1);
    #1;
    check_model();
  endtask

  initial begin
    req = '0; code = '0; rst_n = 1'b0;
    #2;
    step(4'b0000, 16'h0, 1'b0);
    step(4'b1111, 16'hFFFF, 1'b0);
    chk("rst_grant", 16'(grant4), 16'h0);
    chk("rst_outs", 16'({dec_in4, dec_en4, done4, busy4}), 16'h0);

    step(4'b0000, 16'h1234, 1'b1);
    chk("idle_grant", 16'(grant4), 16'h0);

    // single requester 2, code A, dwell 4
    step(4'b0100, 16'h0A00, 1'b1);
    chk("s_grant", 16'(grant4), 16'h4);
    chk("s_dec", 16'(dec_in4), 16'hA);
    for (int i = 0; i < 3; i++) step(4'b0000, 16'h0, 1'b1);
    chk("s_grant4", 16'(grant4), 16'h4);
    chk("s_dec4", 16'(dec_in4), 16'hA);
    step(4'b0000, 16'h0, 1'b1);
    chk("s_done", 16'(done4), 16'h4);
    chk("s_gap", 16'({dec_en4, dec_in4, grant4}), 16'h0);
    step(4'b0000, 16'h0, 1'b1);
    chk("s_idle", 16'({done4, busy4, grant4}), 16'h0);

    // all request, 5-cycle rotation
    step(4'b0000, 16'h0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      step(4'b1111, 16'h4321, 1'b1);
      if (i % 5 == 0) begin
        chk("rot_grant", 16'(grant4), 16'(1 << ((i / 5) % 4)));
        chk("rot_dec", 16'(dec_in4), 16'(((i / 5) % 4) + 1));
      end
      if (i % 5 == 4)
        chk("rot_done", 16'(done4), 16'(1 << ((i / 5) % 4)));
    end

    // captured code ignores later changes
    step(4'b0000, 16'h0, 1'b0);
    step(4'b0001, 16'h0003, 1'b1);
    step(4'b0000, 16'h000F, 1'b1);
    chk("cap_dec2", 16'(dec_in4), 16'h3);
    step(4'b0000, 16'h000F, 1'b1);
    step(4'b0000, 16'h000F, 1'b1);
    chk("cap_dec4", 16'(dec_in4), 16'h3);

    // fairness after grant0 completes: ptr=1
    step(4'b0000, 16'h0, 1'b1);
    chk("fair_done0", 16'(done4), 16'h1);
    step(4'b0011, 16'h0, 1'b1);
    chk("fair_g1", 16'(grant4), 16'h2);
    for (int i = 0; i < 4; i++) step(4'b0000, 16'h0, 1'b1);
    step(4'b0011, 16'h0, 1'b1);
    chk("fair_g0", 16'(grant4), 16'h1);

    // reset aborts grant2 with no done pulse
    step(4'b0000, 16'h0, 1'b0);
    step(4'b0100, 16'h0500, 1'b1);
    step(4'b0100, 16'h0500, 1'b1);
    step(4'b0100, 16'h0500, 1'b0);
    chk("abort_outs", 16'({dec_in4, dec_en4, grant4, done4, busy4}), 16'h0);
    step(4'b0011, 16'h0, 1'b1);
    chk("abort_ptr0", 16'(grant4), 16'h1);

    // dwell of one: grant, done, regrant
    step(4'b0000, 16'h0, 1'b0);
    step(4'b1000, 16'h7000, 1'b1);
    chk("d1_grant", 16'(grant1), 16'h8);
    chk("d1_dec", 16'(dec_in1), 16'h7);
    step(4'b1000, 16'h7000, 1'b1);
    chk("d1_done", 16'(done1), 16'h8);
    chk("d1_gap", 16'({grant1, dec_en1}), 16'h0);
    step(4'b1000, 16'h7000, 1'b1);
    chk("d1_regrant", 16'(grant1), 16'h8);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), 16'($urandom),
           ($urandom_range(0, 39) != 0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
